async_fifo_rd_ctrl: RTL and testbench

//  Read-side controller of the asynchronous FIFO. Runs entirely in the read clock domain.

---
 rtl/async_fifo_pkg.sv | 39 +++
 rtl/async_fifo_ptr_sync.sv | 30 +++
 rtl/async_fifo_rd_ctrl.sv | 83 ++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for both sides of the async FIFO.
// Pointers are PTR_W = ADDR_WIDTH+1 bits; the MSB tells laps apart.
package async_fifo_pkg;

    localparam int PTR_MAX = 32;

    typedef logic [PTR_MAX-1:0] ptr_t;

    localparam ptr_t PTR_RST = '0;

    function automatic int ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic ptr_t ptr_mask(input int w);
        ptr_t m;
        if (w >= PTR_MAX)
            m = '1;
        else
            m = (ptr_t'(1) << w) - ptr_t'(1);
        return m;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b, input int w);
        return (b ^ (b >> 1)) & ptr_mask(w);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic ptr_t gray2bin(input ptr_t g, input int w);
        ptr_t gm;
        ptr_t b;
        gm = g & ptr_mask(w);
        b  = '0;
        for (int i = 0; i < PTR_MAX; i++)
            b[i] = ^(gm >> i);
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing into clk.
// Shared by the read and write controllers of the async FIFO.
module async_fifo_ptr_sync
    import async_fifo_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ff [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++)
                ff[i] <= WIDTH'(PTR_RST);
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++)
                ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the async FIFO (read pointer, wptr sync, empty).
// Define ASYNC_FIFO_ALMOST_EMPTY_EN to add R_LEVEL and R_ALMOST_EMPTY.
module async_fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  R_INC,
    input  logic [ADDR_WIDTH:0]   W_Ptr_Gray,
    output logic [ADDR_WIDTH-1:0] R_Addr,
    output logic [ADDR_WIDTH:0]   R_Ptr_Gray,
    output logic                  R_EMPTY
`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
    ,
    output logic [ADDR_WIDTH:0]   R_LEVEL,
    output logic                  R_ALMOST_EMPTY
`endif
);

    localparam int PTR_W = ptr_w(ADDR_WIDTH);

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic [PTR_W-1:0] wq_s;
    logic             rd_ok;

    async_fifo_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (R_CLK),
        .rst_n (R_RST),
        .d     (W_Ptr_Gray),
        .q     (wq_s)
    );

    always_comb begin
        rd_ok      = R_INC & ~R_EMPTY;
        rbin_next  = rbin + PTR_W'(rd_ok);
        rgray_next = PTR_W'(bin2gray(ptr_t'(rbin_next), PTR_W));
    end

    // Empty compares the post-pop pointer, so the last pop sets it at once.
    always_ff @(posedge R_CLK) begin
        if (!R_RST) begin
            rbin       <= PTR_W'(PTR_RST);
            R_Ptr_Gray <= PTR_W'(PTR_RST);
            R_EMPTY    <= 1'b1;
        end else begin
            rbin       <= rbin_next;
            R_Ptr_Gray <= rgray_next;
            R_EMPTY    <= (rgray_next == wq_s);
        end
    end

    assign R_Addr = rbin[ADDR_WIDTH-1:0];

`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
    logic [PTR_W-1:0] wbin_s;
    logic [PTR_W-1:0] lvl_next;

    always_comb begin
        wbin_s   = PTR_W'(gray2bin(ptr_t'(wq_s), PTR_W));
        lvl_next = wbin_s - rbin_next;
    end

    always_ff @(posedge R_CLK) begin
        if (!R_RST) begin
            R_LEVEL        <= '0;
            R_ALMOST_EMPTY <= 1'b1;
        end else begin
            R_LEVEL        <= lvl_next;
            R_ALMOST_EMPTY <= (lvl_next <= PTR_W'(AE_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Scoreboard bench for async_fifo_rd_ctrl against a count-based FIFO model.
// Level checks are active when ASYNC_FIFO_ALMOST_EMPTY_EN is defined.
module tb_async_fifo_rd_ctrl;

    localparam int AW    = 4;
    localparam int SS    = 2;
    localparam int AE    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          R_RST = 1'b0;
    logic          R_INC = 1'b0;
    logic [AW:0]   W_Ptr_Gray = '0;
    logic [AW-1:0] R_Addr;
    logic [AW:0]   R_Ptr_Gray;
    logic          R_EMPTY;
`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
    logic [AW:0]   R_LEVEL;
    logic          R_ALMOST_EMPTY;
`endif

    always #5 clk = ~clk;

    async_fifo_rd_ctrl #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS),
        .AE_THRESH   (AE)
    ) dut (
        .R_CLK          (clk),
        .R_RST          (R_RST),
        .R_INC          (R_INC),
        .W_Ptr_Gray     (W_Ptr_Gray),
        .R_Addr         (R_Addr),
        .R_Ptr_Gray     (R_Ptr_Gray),
        .R_EMPTY        (R_EMPTY)
`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
        ,
        .R_LEVEL        (R_LEVEL),
        .R_ALMOST_EMPTY (R_ALMOST_EMPTY)
`endif
    );

    typedef struct {
        logic rst_n;
        int   addr;
        int   gray;
        logic empty;
        int   level;
        logic ae;
    } exp_t;

    exp_t sbq[$];

    int   n_chk = 0;
    int   n_fail = 0;
    int   rcnt = 0;
    int   wcnt = 0;
    int   dq[SS];
    logic m_empty = 1'b1;

    function automatic logic [AW:0] gray_of(input int n);
        logic [AW:0] b;
        b = (AW+1)'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: reads/writes as unbounded counts; writes seen SS edges late.
    task automatic step(input logic rn, input logic inc);
        exp_t e;
        int   vis;
        vis = 0;
        @(negedge clk);
        R_RST = rn;
        R_INC = inc;
        if (rn)
            W_Ptr_Gray = gray_of(wcnt);
        if (!rn) begin
            rcnt    = 0;
            m_empty = 1'b1;
            for (int i = 0; i < SS; i++)
                dq[i] = 0;
        end else begin
            vis = dq[SS-1];
            if (inc && !m_empty)
                rcnt++;
            m_empty = (rcnt == vis);
            for (int i = SS - 1; i > 0; i--)
                dq[i] = dq[i-1];
            dq[0] = wcnt;
        end
        e.rst_n = rn;
        e.addr  = rcnt % DEPTH;
        e.gray  = int'(gray_of(rcnt));
        e.empty = m_empty;
        e.level = rn ? vis - rcnt : 0;
        e.ae    = (e.level <= AE);
        sbq.push_back(e);
    endtask

    function automatic logic room();
        return (wcnt + 1 - rcnt) <= DEPTH;
    endfunction

    initial begin
        exp_t        e;
        logic [AW:0] pg;
        logic        pv;
        pg = '0;
        pv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("r_addr", 32'(R_Addr), e.addr);
                chk("r_ptr_gray", 32'(R_Ptr_Gray), e.gray);
                chk("r_empty", 32'(R_EMPTY), 32'(e.empty));
`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
                chk("r_level", 32'(R_LEVEL), e.level);
                chk("r_almost_empty", 32'(R_ALMOST_EMPTY), 32'(e.ae));
`endif
                if (pv && e.rst_n)
                    chk("gray_one_bit",
                        32'($countones(pg ^ R_Ptr_Gray) <= 1), 32'd1);
                pg = R_Ptr_Gray;
                pv = e.rst_n;
            end
        end
    end

    initial begin
        int   lat;
        logic seen;
        logic rn;

        // Reset held with a pending pointer and read request.
        W_Ptr_Gray = 5'b00011;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        wcnt = 0;

        // Underflow: requests while empty are ignored.
        repeat (5) step(1'b1, 1'b1);

        // Single write: visible SS+1 edges after it is first sampled.
        wcnt = 1;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            step(1'b1, 1'b0);
            @(posedge clk);
            #1;
            if (!R_EMPTY) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        chk("write_latency", lat, SS + 1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);

        // Stream 40 entries through, crossing the pointer wrap.
        for (int i = 0; i < 80; i++) begin
            if (wcnt < 40 && room())
                wcnt++;
            step(1'b1, 1'b1);
        end
        @(posedge clk);
        #1;
        chk("wrap_final_gray", 32'(R_Ptr_Gray), 32'(5'b01100));

        // Full FIFO written in one jump, then drained.
        wcnt = 0;
        step(1'b0, 1'b0);
        wcnt = DEPTH;
        repeat (25) step(1'b1, 1'b1);

        // Almost-empty around level 4, with a reset mid-drain.
        wcnt = 0;
        step(1'b0, 1'b0);
        wcnt = 4;
        repeat (4) step(1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1);
        wcnt = 0;
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rn = ($urandom_range(0, 199) != 0);
            if (!rn)
                wcnt = 0;
            else if ($urandom_range(0, 2) != 0 && room())
                wcnt++;
            step(rn, 1'($urandom_range(0, 1)));
        end
        repeat (4) step(1'b1, 1'b0);

        for (int i = 0; i < 10 && sbq.size() > 0; i++)
            @(posedge clk);
        #2;
        if (sbq.size() != 0)
            chk("scoreboard_drain", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
